// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: WIDTH-bit registered logic/arithmetic unit with a fixed
// two-stage pipeline, valid/ready flow control and a completed-op counter.
//
// Handshake: a beat moves on a port when valid and ready are both high at a
// rising edge. The producer keeps valid asserted until the transfer happens.
// in_ready is a combinational function of out_valid/out_ready only (never of
// in_valid). Both stages advance together whenever the output register is
// empty or the sink is taking its current result.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;

    logic             advance;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH:0]   f_wide;
    logic [WIDTH-1:0] f_result;
    logic             f_carry;

    // The whole pipe moves when the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: capture operands and op; holds while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= op;
        end
    end

    // Operation decode on the stage-1 operands. For SUB the extra top bit of
    // the (WIDTH+1)-bit difference is the borrow, i.e. set exactly when a < b.
    always_comb begin
        f_wide   = '0;
        f_result = '0;
        f_carry  = 1'b0;
        case (s1_op)
            OP_AND:  f_result = s1_a & s1_b;
            OP_OR:   f_result = s1_a | s1_b;
            OP_XOR:  f_result = s1_a ^ s1_b;
            OP_NOT:  f_result = ~s1_a;
            OP_ADD: begin
                f_wide   = {1'b0, s1_a} + {1'b0, s1_b};
                f_result = f_wide[WIDTH-1:0];
                f_carry  = f_wide[WIDTH];
            end
            OP_SUB: begin
                f_wide   = {1'b0, s1_a} - {1'b0, s1_b};
                f_result = f_wide[WIDTH-1:0];
                f_carry  = f_wide[WIDTH];
            end
            OP_PASS: f_result = s1_b;
            default: f_result = '0;
        endcase
    end

    // Stage 2: register result and flags; only a valid stage-1 op overwrites
    // them, so the last computed value persists while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= f_result;
                zero   <= (f_result == '0);
                carry  <= f_carry;
            end
        end
    end

    // Count results taken by the sink; wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized and directed checks of logic_unit_pipe
// against a behavioural model, using three instances (8-bit, 2-bit counter,
// 1-bit width).
module tb_logic_unit_pipe;

  logic clk;
  logic rst_n;

  // main instance: WIDTH=8, CNT_W=8
  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [7:0] m_a, m_b, m_result, m_op_count;
  logic [2:0] m_op;
  logic       m_zero, m_carry;

  // counter-wrap instance: WIDTH=8, CNT_W=2
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_a, c_b, c_result;
  logic [1:0] c_op_count;
  logic [2:0] c_op;
  logic       c_zero, c_carry;

  // 1-bit instance: WIDTH=1, CNT_W=8
  logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic       w_a, w_b, w_result;
  logic [7:0] w_op_count;
  logic [2:0] w_op;
  logic       w_zero, w_carry;

  int n_cmp;
  int n_bad;

  logic [9:0] exp_q[$];
  logic [2:0] wq[$];

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .op(m_op), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .result(m_result), .zero(m_zero), .carry(m_carry), .op_count(m_op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .a(c_a), .b(c_b), .op(c_op), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .result(c_result), .zero(c_zero), .carry(c_carry), .op_count(c_op_count)
  );

  logic_unit_pipe #(.WIDTH(1), .CNT_W(8)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_result), .zero(w_zero), .carry(w_carry), .op_count(w_op_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {carry, zero, result} from the operation table.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                        input logic [2:0] o);
    int s;
    logic [7:0] r;
    logic c;
    c = 1'b0;
    r = 8'd0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~x;
      3'd4: begin s = int'(x) + int'(y); r = 8'(s % 256); c = (s > 255); end
      3'd5: begin s = int'(x) - int'(y); r = 8'((s + 256) % 256); c = (x < y); end
      3'd6: r = y;
      default: r = 8'd0;
    endcase
    return {c, (r == 8'd0), r};
  endfunction

  // driver tasks
  task automatic idle_inputs();
    m_in_valid = 1'b0; m_out_ready = 1'b1; m_a = 8'd0; m_b = 8'd0; m_op = 3'd0;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_a = 8'd0; c_b = 8'd0; c_op = 3'd0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = 1'b0; w_b = 1'b0; w_op = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid); end
    n_cmp++; if (m_result !== 8'h00) begin n_bad++; $display("FAIL reset_result: got %h want 00", m_result); end
    n_cmp++; if (m_zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b want 0", m_zero); end
    n_cmp++; if (m_carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b want 0", m_carry); end
    n_cmp++; if (m_op_count !== 8'd0) begin n_bad++; $display("FAIL reset_op_count: got %0d want 0", m_op_count); end
    n_cmp++; if (m_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready); end
    n_cmp++; if (c_op_count !== 2'd0) begin n_bad++; $display("FAIL reset_cnt2: got %0d want 0", c_op_count); end
    n_cmp++; if (w_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_w1_valid: got %b want 0", w_out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ops 000..011 on F0/3C back-to-back; cycle k's input is accepted at the
  // following edge and appears two edges later.
  task automatic test_logic_ops();
    logic [7:0] exp_r[4];
    logic       vexp;
    exp_r = '{8'h30, 8'hFC, 8'hCC, 8'h0F};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      m_in_valid = (k < 4); m_a = 8'hF0; m_b = 8'h3C; m_op = 3'(k); m_out_ready = 1'b1;
      @(negedge clk);
      vexp = (k >= 2 && k <= 5);
      n_cmp++; if (m_out_valid !== vexp) begin n_bad++; $display("FAIL logic_valid c%0d: got %b want %b", k, m_out_valid, vexp); end
      if (k < 4) begin
        n_cmp++; if (m_in_ready !== 1'b1) begin n_bad++; $display("FAIL logic_in_ready c%0d: got %b want 1", k, m_in_ready); end
      end
      if (vexp) begin
        n_cmp++; if (m_result !== exp_r[k-2]) begin n_bad++; $display("FAIL logic_result c%0d: got %h want %h", k, m_result, exp_r[k-2]); end
        n_cmp++; if ({m_carry, m_zero} !== 2'b00) begin n_bad++; $display("FAIL logic_flags c%0d: got %b%b want 00", k, m_carry, m_zero); end
      end
      if (k == 7) begin
        n_cmp++; if (m_op_count !== 8'd4) begin n_bad++; $display("FAIL logic_op_count: got %0d want 4", m_op_count); end
      end
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0;
  endtask

  // add carry/zero, sub borrow, pass-b and forced zero
  task automatic test_arith();
    logic [7:0] ta[4], tb[4], tr[4];
    logic [2:0] to[4];
    logic [1:0] tf[4];
    ta = '{8'hFF, 8'h05, 8'h12, 8'hFF};
    tb = '{8'h01, 8'h07, 8'h34, 8'hFF};
    to = '{3'd4, 3'd5, 3'd6, 3'd7};
    tr = '{8'h00, 8'hFE, 8'h34, 8'h00};
    tf = '{2'b11, 2'b10, 2'b00, 2'b01};   // {carry, zero}
    do_reset();
    for (int k = 0; k < 6; k++) begin
      m_in_valid = (k < 4); m_out_ready = 1'b1;
      if (k < 4) begin m_a = ta[k]; m_b = tb[k]; m_op = to[k]; end
      @(negedge clk);
      if (k >= 2) begin
        n_cmp++; if (m_out_valid !== 1'b1) begin n_bad++; $display("FAIL arith_valid c%0d: got %b want 1", k, m_out_valid); end
        n_cmp++; if (m_result !== tr[k-2]) begin n_bad++; $display("FAIL arith_result op%0d: got %h want %h", to[k-2], m_result, tr[k-2]); end
        n_cmp++; if ({m_carry, m_zero} !== tf[k-2]) begin n_bad++; $display("FAIL arith_flags op%0d: got %b%b want %b", to[k-2], m_carry, m_zero, tf[k-2]); end
      end
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0;
  endtask

  // Streams n random ops. rnd=0: out_ready low for cycles 3..5; rnd=1:
  // random in_valid and out_ready. Scoreboard checks order, uniqueness,
  // hold-while-stalled, in_ready and op_count.
  task automatic test_stream(input int n, input bit rnd);
    int sent, got, exp_cnt;
    logic [7:0] held;
    logic stalled_prev;
    logic [9:0] e;
    logic want_ready;
    do_reset();
    exp_q.delete();
    sent = 0; got = 0; exp_cnt = 0; stalled_prev = 1'b0; held = 8'd0;
    for (int cyc = 0; cyc < 2000 && got < n; cyc++) begin
      if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        m_in_valid = 1'b1; m_a = 8'($urandom); m_b = 8'($urandom); m_op = 3'($urandom_range(0, 7));
      end else begin
        m_in_valid = 1'b0;
      end
      m_out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      n_cmp++; if (m_op_count !== 8'(exp_cnt)) begin n_bad++; $display("FAIL stream_op_count c%0d: got %0d want %0d", cyc, m_op_count, exp_cnt); end
      want_ready = !(m_out_valid && !m_out_ready);
      n_cmp++; if (m_in_ready !== want_ready) begin n_bad++; $display("FAIL stream_in_ready c%0d: got %b want %b", cyc, m_in_ready, want_ready); end
      if (stalled_prev) begin
        n_cmp++; if (m_out_valid !== 1'b1 || m_result !== held) begin n_bad++; $display("FAIL stream_hold c%0d: got %b/%h want 1/%h", cyc, m_out_valid, m_result, held); end
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(model8(m_a, m_b, m_op));
        sent++;
      end
      if (m_out_valid && m_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra c%0d: got result %h want none", cyc, m_result);
        end else begin
          e = exp_q.pop_front();
          if ({m_carry, m_zero, m_result} !== e) begin
            n_bad++; $display("FAIL stream_data #%0d: got c%b z%b %h want c%b z%b %h", got, m_carry, m_zero, m_result, e[9], e[8], e[7:0]);
          end
        end
        got++;
        exp_cnt++;
      end
      stalled_prev = m_out_valid && !m_out_ready;
      held = m_result;
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    n_cmp++; if (got != n) begin n_bad++; $display("FAIL stream_count: got %0d results want %0d", got, n); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_dup c%0d: got out_valid %b want 0", k, m_out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    test_stream(5, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_stream(60, 1'b1);
  endtask

  // Reset with two ops in flight; nothing stale may emerge afterwards.
  task automatic test_reset_flight();
    logic [9:0] e;
    do_reset();
    m_out_ready = 1'b1;
    m_in_valid = 1'b1; m_a = 8'h11; m_b = 8'h22; m_op = 3'd4;
    @(posedge clk); #1;
    m_a = 8'h40; m_b = 8'h01; m_op = 3'd5;
    @(posedge clk); #1;
    m_in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL flight_valid: got %b want 0", m_out_valid); end
    n_cmp++; if (m_op_count !== 8'd0) begin n_bad++; $display("FAIL flight_op_count: got %0d want 0", m_op_count); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL flight_stale c%0d: got %b want 0", k, m_out_valid); end
      @(posedge clk); #1;
    end
    m_in_valid = 1'b1; m_a = 8'h0F; m_b = 8'hF0; m_op = 3'd1;
    e = model8(m_a, m_b, m_op);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_out_valid !== 1'b0) begin n_bad++; $display("FAIL flight_early: got %b want 0", m_out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (m_out_valid !== 1'b1 || m_result !== e[7:0]) begin n_bad++; $display("FAIL flight_new: got %b/%h want 1/%h", m_out_valid, m_result, e[7:0]); end
    @(posedge clk); #1;
  endtask

  // CNT_W=2: five transfers give 1,2,3,0,1
  task automatic test_cnt_wrap();
    int ex;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      c_in_valid = (k < 5); c_a = 8'($urandom); c_b = 8'($urandom); c_op = 3'($urandom_range(0, 7));
      c_out_ready = 1'b1;
      @(negedge clk);
      ex = (k < 3) ? 0 : ((k - 2) % 4);
      n_cmp++; if (c_op_count !== 2'(ex)) begin n_bad++; $display("FAIL cnt_wrap c%0d: got %0d want %0d", k, c_op_count, ex); end
      @(posedge clk); #1;
    end
    c_in_valid = 1'b0;
  endtask

  // WIDTH=1: original gate truth tables plus op 111
  task automatic test_width1();
    logic [3:0] tt[4];
    logic [2:0] e;
    logic r;
    int got;
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};   // indexed by {a,b}
    do_reset();
    wq.delete();
    got = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      w_out_ready = 1'b1;
      if (cyc < 16) begin
        w_in_valid = 1'b1; w_op = 3'(cyc / 4); w_a = cyc[1]; w_b = cyc[0];
      end else if (cyc < 18) begin
        w_in_valid = 1'b1; w_op = 3'd7; w_a = 1'b1; w_b = cyc[0];
      end else begin
        w_in_valid = 1'b0;
      end
      @(negedge clk);
      if (w_in_valid && w_in_ready) begin
        r = (w_op == 3'd7) ? 1'b0 : tt[w_op[1:0]][{w_a, w_b}];
        wq.push_back({1'b0, !r, r});
      end
      if (w_out_valid && w_out_ready) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++; $display("FAIL w1_extra c%0d: got %b want none", cyc, w_result);
        end else begin
          e = wq.pop_front();
          if ({w_carry, w_zero, w_result} !== e) begin
            n_bad++; $display("FAIL w1_data #%0d: got c%b z%b r%b want c%b z%b r%b", got, w_carry, w_zero, w_result, e[2], e[1], e[0]);
          end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (got != 18) begin n_bad++; $display("FAIL w1_count: got %0d want 18", got); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_logic_ops();
    test_arith();
    test_stall();
    test_back_to_back();
    test_reset_flight();
    test_cnt_wrap();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
